// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its datapath.
package alu_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_t;

  // Bit positions inside the {N,Z,C,V} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR with {N,Z,C,V} flags.
// Zero latency; no flow control.
module alu
  import alu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic        carry;
  logic        ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: bit 32 is the not-borrow, i.e. set when a >= b unsigned.
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    result = sum[31:0];
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ADD: begin
        result = sum[31:0];
        carry  = sum[32];
        ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      SUB: begin
        result = diff[31:0];
        carry  = diff[32];
        ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      AND: result = a & b;
      OR:  result = a | b;
      default: ;
    endcase
  end

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = result[31];
    flags[FLAG_Z] = (result == 32'd0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; result registered, 1-cycle latency.
// Response held stable while rsp_ready=0 (req_ready=00 then); drains and refills in the same cycle.
module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][1:0]  req_op,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [31:0]              rsp_result,
  output logic [3:0]               rsp_flags,
  output logic [15:0]              op_count
);

  import alu_pkg::*;

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic        ptr;          // requester that wins the next tie
  logic        gnt;
  logic        accept_ok;
  logic        accept;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

  always_comb begin
    gnt = ptr;
    if (req_valid[0] && !req_valid[1])
      gnt = 1'b0;
    else if (req_valid[1] && !req_valid[0])
      gnt = 1'b1;
  end

  assign accept_ok = reset && ((state == IDLE) || rsp_ready);
  assign accept    = |(req_valid & req_ready);

  alu u_alu (
    .op     (alu_op_t'(req_op[gnt])),
    .a      (req_a[gnt]),
    .b      (req_b[gnt]),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = HOLD;
      HOLD: if (rsp_ready && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept_ok && (|req_valid))
      req_ready[gnt] = 1'b1;
    rsp_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr        <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_flags  <= 4'd0;
      op_count   <= 16'd0;
    end else begin
      if (accept) begin
        ptr        <= ~gnt;
        rsp_id     <= gnt;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end
      if (rsp_valid && rsp_ready)
        op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [15:0]      op_count;

  int tests = 0;
  int fails = 0;

  // Model: one pending response slot, who was granted last, completion count.
  bit          m_pend;
  bit          m_id;
  logic [31:0] m_res;
  logic [3:0]  m_flg;
  bit          m_last;
  logic [15:0] m_cnt;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s  = 0;
    bit c = 0;
    bit v = 0;
    case (op)
      2'd0: begin
        r = a + b;
        c = ((longint'(a) + longint'(b)) > 64'hFFFF_FFFF);
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  function automatic bit pick_grant(input logic [1:0] valid, input bit last);
    if (valid == 2'b11) return !last;
    return valid[1];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Inputs are already driven; check settled outputs, then clock and advance the model.
  task automatic cycle();
    bit          can;
    bit          g;
    logic [1:0]  exp_rdy;
    logic [31:0] r;
    logic [3:0]  f;
    #3;
    can     = reset && (!m_pend || rsp_ready);
    g       = pick_grant(req_valid, m_last);
    exp_rdy = 2'b00;
    if (can && (req_valid != 2'b00)) exp_rdy = g ? 2'b10 : 2'b01;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    if (m_pend) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_flags", 32'(rsp_flags), 32'(m_flg));
    end
    @(posedge clk);
    if (!reset) begin
      m_pend = 0; m_id = 0; m_res = 0; m_flg = 0; m_last = 1; m_cnt = 0;
    end else begin
      if (m_pend && rsp_ready) begin
        m_cnt  = m_cnt + 16'd1;
        m_pend = 0;
      end
      if (can && (req_valid != 2'b00)) begin
        ref_alu(req_op[g], req_a[g], req_b[g], r, f);
        m_pend = 1; m_id = g; m_res = r; m_flg = f; m_last = g;
      end
    end
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp[4];
    int         n;
    m_pend = 0; m_id = 0; m_res = 0; m_flg = 0; m_last = 1; m_cnt = 0;
    reset = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;

    // Reset held with both requesting
    cycle();
    cycle();
    chk("reset_result", rsp_result, 32'h0);
    chk("reset_flags", 32'(rsp_flags), 32'h0);
    chk("reset_id", 32'(rsp_id), 32'h0);

    // Single ADD overflowing into the sign bit
    reset = 1'b1; req_valid = 2'b01;
    req_op[0] = 2'b00; req_a[0] = 32'h7FFF_FFFF; req_b[0] = 32'h0000_0001;
    cycle();
    req_valid = 2'b00;
    #3;
    chk("add_valid", 32'(rsp_valid), 32'h1);
    chk("add_id", 32'(rsp_id), 32'h0);
    chk("add_result", rsp_result, 32'h8000_0000);
    chk("add_flags", 32'(rsp_flags), 32'b1001);
    cycle();
    rsp_ready = 1'b1;
    cycle();

    // Lone request from 1 so requester 0 owns the next tie
    req_valid = 2'b10; req_op[1] = 2'b10; req_a[1] = 32'hF0F0; req_b[1] = 32'hFF00;
    cycle();

    // Round-robin with both requesting continuously
    req_valid = 2'b11;
    req_op[0] = 2'b11; req_a[0] = 32'h1234_0000; req_b[0] = 32'h0000_5678;
    req_op[1] = 2'b01; req_a[1] = 32'd5;         req_b[1] = 32'd5;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("rr_grant", 32'(req_ready), 32'(rr_exp[i]));
      if (i >= 2 && rsp_id == 1'b1) begin
        chk("sub_result", rsp_result, 32'h0);
        chk("sub_flags", 32'(rsp_flags), 32'b0110);
      end
      cycle();
    end

    // Backpressure: three stalled cycles, then drain and refill together
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rsp_ready = 1'b1;
    #3;
    chk("bp_refill", 32'(req_ready != 2'b00), 32'h1);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) != 0);
      req_valid = 2'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        req_op[k] = 2'($urandom());
        req_a[k]  = rand_operand();
        req_b[k]  = rand_operand();
      end
      cycle();
    end

    // Reset while holding a response
    reset = 1'b1; rsp_ready = 1'b1; req_valid = 2'b00;
    cycle();
    rsp_ready = 1'b0; req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    reset = 1'b0;
    cycle();
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    #3;
    chk("midrst_tie", 32'(req_ready), 32'b01);
    cycle();

    // Completion counter wrap
    reset = 1'b0;
    cycle();
    reset = 1'b1; req_valid = 2'b01; rsp_ready = 1'b1;
    req_op[0] = 2'b00; req_a[0] = 32'd1; req_b[0] = 32'd2;
    n = 0;
    while (m_cnt != 16'hFFFF && n < 70000) begin
      cycle();
      n++;
    end
    #3;
    chk("wrap_full", 32'(op_count), 32'hFFFF);
    cycle();
    chk("wrap_zero", 32'(op_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, the number of requesters (fixed at 2 for this release).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
REQ-004 The block SHALL have port req_valid  input  2  per-requester request valid.
REQ-005 The block SHALL have port req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 The block SHALL have port req_op  input  2x2  per-requester ALU control code: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 The block SHALL have port req_a  input  2x32  per-requester operand a.
REQ-008 The block SHALL have port req_b  input  2x32  per-requester operand b.
REQ-009 The block SHALL have port rsp_valid  output  1  response valid.
REQ-010 The block SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 The block SHALL have port rsp_id  output  1  index of requester that owns the response.
REQ-012 The block SHALL have port rsp_result  output  32  ALU result.
REQ-013 The block SHALL have port rsp_flags  output  4  ALU flags {N,Z,C,V}.
REQ-014 The block SHALL have port op_count  output  16  count of completed responses.

Function
REQ-015 State machine SHALL have two states: IDLE (output register empty) and HOLD (output register full).
REQ-016 A request SHALL be accepted in a cycle when state is IDLE, or state is HOLD with rsp_ready=1 (slot frees that cycle).
REQ-017 When acceptance is possible and any req_valid is high, req_ready SHALL assert combinationally for exactly one granted requester; otherwise req_ready=00.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted most recently; with one valid, grant it regardless of pointer.
REQ-019 The round-robin pointer SHALL update only on an accepted transfer (req_valid & req_ready).
REQ-020 Granted operands/op SHALL drive the shared alu combinationally; result, flags and grant index SHALL be registered at the accepting edge; latency request-accept to rsp_valid = 1 cycle.
REQ-021 ALU arithmetic SHALL be 32-bit: C = carry-out for ADD, NOT-borrow for SUB (a>=b unsigned), 0 for AND/OR; V = signed overflow for ADD/SUB, 0 for AND/OR; N = result[31]; Z = (result==0).
REQ-022 In HOLD, rsp_valid, rsp_id, rsp_result, rsp_flags SHALL remain stable until rsp_ready=1.
REQ-023 HOLD with rsp_ready=1 and a new accepted request SHALL stay in HOLD with new response next cycle (back-to-back, no bubble).
REQ-024 HOLD with rsp_ready=1 and no request SHALL return to IDLE; rsp_valid=0 next cycle.
REQ-025 rsp_ready while IDLE SHALL be ignored.
REQ-026 op_count SHALL increment by 1 on each rsp_valid & rsp_ready, wrapping 0xFFFF -> 0x0000.
REQ-027 Requester inputs changing while not granted SHALL have no effect.

Reset
REQ-028 On reset=0 at a rising edge: state IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, op_count=0, pointer set so requester 0 wins the first tie.
REQ-029 While reset=0, req_ready SHALL be 00; reset during HOLD SHALL discard the pending response.

Structure
REQ-030 Package alu_pkg SHALL hold alu_op_t enum (ADD, SUB, AND, OR), flag index constants (N=3, Z=2, C=1, V=0) and NUM_REQ.
REQ-031 The block SHALL instantiate exactly one existing alu sub-module as the shared datapath; no second ALU.

Verification
REQ-032 Reset: hold reset=0 two cycles with req_valid=11 -> req_ready=00, rsp_valid=0, op_count=0.
REQ-033 Single ADD: req0 a=0x7FFFFFFF b=0x00000001 op=00 -> next cycle rsp_id=0, result=0x80000000, flags=1001.
REQ-034 Round-robin: both valid continuously, rsp_ready=1 -> grants 0,1,0,1; req1 SUB a=5 b=5 -> result 0, flags=0110.
REQ-035 Backpressure: rsp_ready=0 for 3 cycles after response -> outputs stable, req_ready=00, then rsp_ready=1 accepts next request same cycle.
REQ-036 Wrap: preload 0xFFFF completions -> next completion op_count=0x0000.
REQ-037 Mid-operation reset: assert reset=0 while HOLD -> rsp_valid=0 next cycle, tie goes to requester 0 after release.
